// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined add/sub (ADD/SUB/ADC/SBB) built on two-level carry lookahead, with status flags.
// Latency: a beat accepted at edge t is presented after edge t+1; up to 1 result per cycle.
// Backpressure: stalls hold stage 2 stable, stage 1 fills, then in_ready drops (2 beats max in flight).
module cla_addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [1:0]       in_op,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_c,
  output logic             out_v,
  output logic             out_z,
  output logic             out_n
);
  localparam int NG = WIDTH / GROUP;

  logic [WIDTH-1:0] yc, bg, bp;
  logic             c0;
  logic [NG-1:0]    grp_g, grp_p;

  logic             v1, v2, adv1, adv2;
  logic [WIDTH-1:0] p1, g1;
  logic             c01;
  logic [NG-1:0]    gg1, gp1;

  logic [NG:0]      gc;
  logic [WIDTH:0]   cy;
  logic [WIDTH-1:0] s_nxt;

  assign adv2     = !v2 || out_ready;
  assign adv1     = !v1 || adv2;
  assign in_ready = adv1;

  always_comb begin
    yc = in_y ^ {WIDTH{in_op[0]}};
    bg = in_x & yc;
    bp = in_x ^ yc;
    c0 = in_op[1] ? in_cin : in_op[0];
  end

  // Group generate as a flat sum of products over the bits of each group.
  always_comb begin : group_gp
    logic term;
    term  = 1'b0;
    grp_g = '0;
    grp_p = '0;
    for (int j = 0; j < NG; j++) begin
      grp_p[j] = &bp[j*GROUP +: GROUP];
      for (int k = 0; k < GROUP; k++) begin
        term = bg[j*GROUP+k];
        for (int m = k + 1; m < GROUP; m++) term = term & bp[j*GROUP+m];
        grp_g[j] = grp_g[j] | term;
      end
    end
  end

  // Bit generates are kept alongside p: in-group carries need them in stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      p1  <= '0;
      g1  <= '0;
      c01 <= 1'b0;
      gg1 <= '0;
      gp1 <= '0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        p1  <= bp;
        g1  <= bg;
        c01 <= c0;
        gg1 <= grp_g;
        gp1 <= grp_p;
      end
    end
  end

  always_comb begin : carries
    logic term;
    int   b;
    term  = 1'b0;
    b     = 0;
    gc    = '0;
    cy    = '0;
    gc[0] = c01;
    for (int j = 0; j < NG; j++) begin
      for (int k = 0; k <= j; k++) begin
        term = gg1[k];
        for (int m = k + 1; m <= j; m++) term = term & gp1[m];
        gc[j+1] = gc[j+1] | term;
      end
      term = c01;
      for (int m = 0; m <= j; m++) term = term & gp1[m];
      gc[j+1] = gc[j+1] | term;
    end
    // In-group carries look ahead from the group carry-in; i == 0 reduces to gc[j].
    for (int j = 0; j < NG; j++) begin
      b = j * GROUP;
      for (int i = 0; i < GROUP; i++) begin
        for (int k = 0; k < i; k++) begin
          term = g1[b+k];
          for (int m = k + 1; m < i; m++) term = term & p1[b+m];
          cy[b+i] = cy[b+i] | term;
        end
        term = gc[j];
        for (int m = 0; m < i; m++) term = term & p1[b+m];
        cy[b+i] = cy[b+i] | term;
      end
    end
    cy[WIDTH] = gc[NG];
  end

  assign s_nxt = p1 ^ cy[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      out_s <= '0;
      out_c <= 1'b0;
      out_v <= 1'b0;
      out_z <= 1'b0;
      out_n <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        out_s <= s_nxt;
        out_c <= cy[WIDTH];
        out_v <= cy[WIDTH] ^ cy[WIDTH-1];
        out_z <= (s_nxt == '0);
        out_n <= s_nxt[WIDTH-1];
      end
    end
  end

  assign out_valid = v2;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Bench for cla_addsub_pipe: directed cases on a 16/4 instance, then random streams on 16/4 and 32/8.
module tb_cla_addsub_pipe;

  typedef struct packed {
    logic        c;
    logic        v;
    logic        z;
    logic        n;
    logic [31:0] s;
  } res_t;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ADC = 2'b10, SBB = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid = 1'b0, in_ready, in_cin = 1'b0;
  logic [15:0] in_x = '0, in_y = '0;
  logic [1:0]  in_op = '0;
  logic        out_valid, out_ready = 1'b1, out_c, out_v, out_z, out_n;
  logic [15:0] out_s;

  logic        w_in_valid = 1'b0, w_in_ready, w_in_cin = 1'b0;
  logic [31:0] w_in_x = '0, w_in_y = '0;
  logic [1:0]  w_in_op = '0;
  logic        w_out_valid, w_out_ready = 1'b1, w_out_c, w_out_v, w_out_z, w_out_n;
  logic [31:0] w_out_s;

  int n_cmp = 0, n_err = 0;
  int n16_ret = 0, n32_ret = 0;
  res_t q16[$], q32[$];

  always #5 clk = ~clk;

  cla_addsub_pipe #(.WIDTH(16), .GROUP(4)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .in_op(in_op), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s),
    .out_c(out_c), .out_v(out_v), .out_z(out_z), .out_n(out_n)
  );

  cla_addsub_pipe #(.WIDTH(32), .GROUP(8)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_x(w_in_x), .in_y(w_in_y),
    .in_op(w_in_op), .in_cin(w_in_cin),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_s(w_out_s),
    .out_c(w_out_c), .out_v(w_out_v), .out_z(w_out_z), .out_n(w_out_n)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain wide integer add, overflow from operand/result sign bits.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic [1:0] op, input logic cin, input int w);
    logic [63:0] mask, ycond, sum;
    logic        cz;
    res_t        r;
    mask  = (64'd1 << w) - 64'd1;
    ycond = (op[0] ? ~{32'd0, y} : {32'd0, y}) & mask;
    cz    = (op == ADD) ? 1'b0 : (op == SUB) ? 1'b1 : cin;
    sum   = {32'd0, x} + ycond + {63'd0, cz};
    r.s   = sum[31:0] & mask[31:0];
    r.c   = sum[w];
    r.n   = r.s[w-1];
    r.z   = (r.s == 32'd0);
    r.v   = (x[w-1] == ycond[w-1]) && (r.s[w-1] != x[w-1]);
    return r;
  endfunction

  function automatic res_t got16();
    res_t r;
    r = '{c: out_c, v: out_v, z: out_z, n: out_n, s: {16'd0, out_s}};
    return r;
  endfunction

  // Handshakes are judged at the negedge, where everything is stable until the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      res_t e, g;
      if (out_valid && out_ready) begin
        n16_ret++;
        if (q16.size() == 0) check("s16_extra", 64'(q16.size()), 64'd1);
        else begin
          e = q16.pop_front();
          check("s16_result", 64'(got16()), 64'(e));
        end
      end
      if (in_valid && in_ready) q16.push_back(model({16'd0, in_x}, {16'd0, in_y}, in_op, in_cin, 16));
      if (w_out_valid && w_out_ready) begin
        n32_ret++;
        g = '{c: w_out_c, v: w_out_v, z: w_out_z, n: w_out_n, s: w_out_s};
        if (q32.size() == 0) check("s32_extra", 64'(q32.size()), 64'd1);
        else begin
          e = q32.pop_front();
          check("s32_result", 64'(g), 64'(e));
        end
      end
      if (w_in_valid && w_in_ready) q32.push_back(model(w_in_x, w_in_y, w_in_op, w_in_cin, 32));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive16(input logic [15:0] x, input logic [15:0] y, input logic [1:0] op, input logic cin);
    in_x = x; in_y = y; in_op = op; in_cin = cin;
  endtask

  // One beat through with out_ready high; returns the result and checks 2-cycle latency.
  task automatic run1(input string tag, input logic [15:0] x, input logic [15:0] y,
                      input logic [1:0] op, input logic cin, output res_t got);
    int  cnt;
    logic acc;
    drive16(x, y, op, cin);
    in_valid = 1'b1;
    cnt = 0;
    do begin
      acc = in_ready;
      step();
      cnt++;
    end while (!acc && cnt < 20);
    in_valid = 1'b0;
    if (!acc) check({tag, "_accept_timeout"}, 64'(acc), 64'd1);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      step();
      cnt++;
    end
    check({tag, "_latency"}, 64'(cnt), 64'd1);
    got = got16();
  endtask

  logic [15:0] bx[4] = '{16'h0010, 16'h8000, 16'h00FF, 16'h1234};
  logic [15:0] by[4] = '{16'h0003, 16'h0001, 16'h0100, 16'h1234};
  logic [1:0]  bo[4] = '{ADD, SUB, ADD, SUB};

  initial begin
    res_t r, lo, hi, snap;
    int   k, cyc;
    logic acc, have;

    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_flags", 64'({out_s, out_c, out_v, out_z, out_n}), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_idle_valid", 64'(out_valid), 64'd0);

    run1("sub_ovf", 16'h8001, 16'h7FFE, SUB, 1'b0, r);
    check("sub_ovf", 64'(r), 64'({1'b1, 1'b1, 1'b0, 1'b0, 32'h0003}));
    run1("add_wrap", 16'hFFFF, 16'h0001, ADD, 1'b1, r);
    check("add_wrap", 64'(r), 64'({1'b1, 1'b0, 1'b1, 1'b0, 32'h0000}));
    run1("add_ovf", 16'h7FFF, 16'h0001, ADD, 1'b0, r);
    check("add_ovf", 64'(r), 64'({1'b0, 1'b1, 1'b0, 1'b1, 32'h8000}));
    run1("adc", 16'h1234, 16'h0001, ADC, 1'b1, r);
    check("adc", 64'(r), 64'({1'b0, 1'b0, 1'b0, 1'b0, 32'h1236}));
    run1("sbb", 16'h0005, 16'h0005, SBB, 1'b0, r);
    check("sbb", 64'(r), 64'({1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF}));
    run1("chain_lo", 16'hFFFF, 16'h0001, ADC, 1'b0, lo);
    run1("chain_hi", 16'h0001, 16'h0000, ADC, lo.c, hi);
    check("chain32", 64'({hi.s[15:0], lo.s[15:0]}), 64'h0002_0000);
    step();

    // Backpressure: four back-to-back beats against a stalled sink.
    out_ready = 1'b0;
    k = 0;
    have = 1'b0;
    snap = '0;
    drive16(bx[0], by[0], bo[0], 1'b0);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      acc = in_ready;
      step();
      if (acc) begin
        k++;
        if (k < 4) drive16(bx[k], by[k], bo[k], 1'b0);
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        if (!have) begin
          snap = got16();
          have = 1'b1;
        end else check("stall_hold", 64'(got16()), 64'(snap));
      end
    end
    check("bp_accepted", 64'(k), 64'd2);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1;
    check("bp_ready_comb", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check("bp_stream_valid", 64'(out_valid), 64'd1);
      acc = in_ready;
      step();
      if (acc && in_valid) begin
        k++;
        if (k < 4) drive16(bx[k], by[k], bo[k], 1'b0);
        else in_valid = 1'b0;
      end
    end
    check("bp_drained", 64'(out_valid), 64'd0);
    check("bp_queue_empty", 64'(q16.size()), 64'd0);

    // Reset with two beats in flight.
    out_ready = 1'b0;
    drive16(16'h1111, 16'h2222, ADD, 1'b0);
    in_valid = 1'b1;
    step();
    drive16(16'h3333, 16'h4444, SUB, 1'b0);
    step();
    in_valid = 1'b0;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_s", 64'(out_s), 64'd0);
    q16.delete();
    step();
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check("post_rst_no_stale", 64'(out_valid), 64'd0);
      step();
    end

    n16_ret = 0;
    n32_ret = 0;
    fork
      begin
        int acc16 = 0;
        cyc = 0;
        while (acc16 < 1000 && cyc < 20000) begin
          in_valid  = ($urandom_range(0, 3) != 0);
          drive16(16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)), 1'($urandom));
          out_ready = ($urandom_range(0, 3) != 0);
          #1;
          if (in_valid && in_ready) acc16++;
          step();
          cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("s16_accepts", 64'(acc16), 64'd1000);
      end
      begin
        int acc32 = 0;
        int wcyc = 0;
        while (acc32 < 1000 && wcyc < 20000) begin
          w_in_valid  = ($urandom_range(0, 3) != 0);
          w_in_x      = $urandom;
          w_in_y      = $urandom;
          w_in_op     = 2'($urandom_range(0, 3));
          w_in_cin    = 1'($urandom);
          w_out_ready = ($urandom_range(0, 3) != 0);
          #1;
          if (w_in_valid && w_in_ready) acc32++;
          step();
          wcyc++;
        end
        w_in_valid  = 1'b0;
        w_out_ready = 1'b1;
        check("s32_accepts", 64'(acc32), 64'd1000);
      end
    join
    for (int i = 0; i < 20 && (q16.size() != 0 || q32.size() != 0); i++) step();
    step();
    check("s16_queue_empty", 64'(q16.size()), 64'd0);
    check("s32_queue_empty", 64'(q32.size()), 64'd0);
    check("s16_retired", 64'(n16_ret), 64'd1000);
    check("s32_retired", 64'(n32_ret), 64'd1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
